// File: rtl/c3lib_mtie_strap_capture.sv
// Qualifies a tie-cell strap vector: settle window, then a run of identical samples
// (or a bounded number of mismatches) before the value is locked and presented.
module c3lib_mtie_strap_capture #(
  parameter int WIDTH          = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_SAMPLES = 3,
  parameter int MAX_RETRY      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             ovrd_en,
  input  logic [WIDTH-1:0] ovrd_val,
  input  logic             recapture,
  output logic [WIDTH-1:0] strap_out,
  output logic             strap_vld,
  output logic             strap_err
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = $clog2(STABLE_SAMPLES);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_ONE   = MW'(1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(STABLE_SAMPLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [MW-1:0]    match_q, match_d;
  logic [3:0]       retry_q, retry_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [3:0]       retry_inc_s;

  assign retry_inc_s = retry_q + 4'd1;

  // Next-state and output-register logic for the qualification sequence.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    settle_d = settle_q;
    match_d  = match_q;
    retry_d  = retry_q;
    ref_d    = ref_q;
    cap_d    = cap_q;
    out_d    = out_q;
    vld_d    = vld_q;
    err_d    = err_q;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          first_d = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_SAMPLE: begin
        if (first_q) begin
          ref_d   = strap_in;
          match_d = MATCH_ONE;
          first_d = 1'b0;
        end else if (strap_in == ref_q) begin
          if (match_q == MATCH_LAST) begin
            cap_d   = ref_q;
            out_d   = ovrd_en ? ovrd_val : ref_q;
            vld_d   = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            match_d = match_q + MW'(1);
          end
        end else begin
          // A mismatch restarts the run; too many of them force a lock on the latest value.
          ref_d   = strap_in;
          match_d = MATCH_ONE;
          err_d   = 1'b1;
          retry_d = retry_inc_s;
          if (retry_inc_s == RETRY_MAX) begin
            cap_d   = strap_in;
            out_d   = ovrd_en ? ovrd_val : strap_in;
            vld_d   = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_LOCKED: begin
        if (recapture) begin
          state_d = ST_SAMPLE;
          first_d = 1'b1;
          match_d = '0;
          retry_d = 4'd0;
          vld_d   = 1'b0;
        end else begin
          out_d = ovrd_en ? ovrd_val : cap_q;
          vld_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_SETTLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      first_q  <= 1'b0;
      settle_q <= '0;
      match_q  <= '0;
      retry_q  <= 4'd0;
      ref_q    <= '0;
      cap_q    <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      retry_q  <= retry_d;
      ref_q    <= ref_d;
      cap_q    <= cap_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign strap_out = out_q;
  assign strap_vld = vld_q;
  assign strap_err = err_q;

endmodule
